decode_issue_ctrl: RTL and testbench

Decode-stage issue controller for the RV64I core. It sits between instruction fetch and execute, and registers each fetched instruction and its PC behind valid/ready handshakes on both sides. It drives the shared immediate generator for the instruction it is presenting and attaches the immediate and an opcode class to that instruction. It also absorbs back-pressure from execute and drops in-flight instructions on a pipeline flush.

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/decode_issue_ctrl_imm_gen.sv | 29 ++
 rtl/decode_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV64I major opcodes, opcode class codes and buffer states.
package decode_pkg;

    localparam logic [6:0] OpcLoad    = 7'h03;
    localparam logic [6:0] OpcOpImm   = 7'h13;
    localparam logic [6:0] OpcAuipc   = 7'h17;
    localparam logic [6:0] OpcOpImm32 = 7'h1b;
    localparam logic [6:0] OpcStore   = 7'h23;
    localparam logic [6:0] OpcOp      = 7'h33;
    localparam logic [6:0] OpcLui     = 7'h37;
    localparam logic [6:0] OpcOp32    = 7'h3b;
    localparam logic [6:0] OpcBranch  = 7'h63;
    localparam logic [6:0] OpcJalr    = 7'h67;
    localparam logic [6:0] OpcJal     = 7'h6f;
    localparam logic [6:0] OpcMiscMem = 7'h0f;
    localparam logic [6:0] OpcSystem  = 7'h73;

    typedef enum logic [3:0] {
        ClsOp       = 4'd0,
        ClsOpImm    = 4'd1,
        ClsLoad     = 4'd2,
        ClsStore    = 4'd3,
        ClsBranch   = 4'd4,
        ClsJal      = 4'd5,
        ClsJalr     = 4'd6,
        ClsLui      = 4'd7,
        ClsAuipc    = 4'd8,
        ClsOp32     = 4'd9,
        ClsOpImm32  = 4'd10,
        ClsFence    = 4'd11,
        ClsSystem   = 4'd12,
        ClsInvalid  = 4'd15
    } inst_class_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/decode_issue_ctrl_imm_gen.sv
// Immediate generator: sign-extended RV64I immediate selected by the major opcode's format.
module decode_issue_ctrl_imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned DATA_LEN = 64
) (
    input  logic [31:0]         inst,
    output logic [DATA_LEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (inst[6:0])
            OpcLoad, OpcOpImm, OpcOpImm32, OpcJalr, OpcMiscMem, OpcSystem:
                imm = {{(DATA_LEN-12){inst[31]}}, inst[31:20]};
            OpcStore:
                imm = {{(DATA_LEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OpcBranch:
                imm = {{(DATA_LEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            OpcLui, OpcAuipc:
                imm = {{(DATA_LEN-32){inst[31]}}, inst[31:12], 12'b0};
            OpcJal:
                imm = {{(DATA_LEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue buffer with immediate/class decode of the head entry.
// Define DECODE_SKID_EN for the two-entry skid buffer with a registered in_ready_o.
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned         DATA_LEN = 64,
    parameter logic [DATA_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_inst_i,
    input  logic [DATA_LEN-1:0] in_pc_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_inst_o,
    output logic [DATA_LEN-1:0] out_pc_o,
    output logic [DATA_LEN-1:0] out_imm_o,
    output logic [3:0]          out_class_o,
    output logic                out_illegal_o
);

    function automatic inst_class_e classify(input logic [31:0] inst);
        if (inst[1:0] != 2'b11) begin
            return ClsInvalid;
        end
        case (inst[6:0])
            OpcOp:      return ClsOp;
            OpcOpImm:   return ClsOpImm;
            OpcLoad:    return ClsLoad;
            OpcStore:   return ClsStore;
            OpcBranch:  return ClsBranch;
            OpcJal:     return ClsJal;
            OpcJalr:    return ClsJalr;
            OpcLui:     return ClsLui;
            OpcAuipc:   return ClsAuipc;
            OpcOp32:    return ClsOp32;
            OpcOpImm32: return ClsOpImm32;
            OpcMiscMem: return ClsFence;
            OpcSystem:  return ClsSystem;
            default:    return ClsInvalid;
        endcase
    endfunction

    buf_state_e          state_q, state_d;
    logic [31:0]         head_inst_q, head_inst_d;
    logic [DATA_LEN-1:0] head_pc_q, head_pc_d;
`ifdef DECODE_SKID_EN
    logic [31:0]         tail_inst_q, tail_inst_d;
    logic [DATA_LEN-1:0] tail_pc_q, tail_pc_d;
`endif
    logic                in_xfer, out_xfer;
    inst_class_e         head_class;

`ifdef DECODE_SKID_EN
    // Ready comes only from the state register, so execute's ready never reaches fetch.
    assign in_ready_o = !flush_i && (state_q != StTwo);
`else
    assign in_ready_o = !flush_i && ((state_q == StEmpty) || out_ready_i);
`endif
    assign out_valid_o = (state_q != StEmpty) && !flush_i;
    assign in_xfer     = in_valid_i && in_ready_o;
    assign out_xfer    = out_valid_o && out_ready_i;

    always_comb begin
        state_d     = state_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
`ifdef DECODE_SKID_EN
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
`endif
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d     = StOne;
                        head_inst_d = in_inst_i;
                        head_pc_d   = in_pc_i;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        head_inst_d = in_inst_i;
                        head_pc_d   = in_pc_i;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
`ifdef DECODE_SKID_EN
                    end else if (in_xfer) begin
                        state_d     = StTwo;
                        tail_inst_d = in_inst_i;
                        tail_pc_d   = in_pc_i;
`endif
                    end
                end
`ifdef DECODE_SKID_EN
                StTwo: begin
                    if (out_xfer) begin
                        state_d     = StOne;
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                    end
                end
`endif
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            head_inst_q <= '0;
            head_pc_q   <= RESET_PC;
`ifdef DECODE_SKID_EN
            tail_inst_q <= '0;
            tail_pc_q   <= RESET_PC;
`endif
        end else begin
            state_q     <= state_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
`ifdef DECODE_SKID_EN
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
`endif
        end
    end

    decode_issue_ctrl_imm_gen #(
        .DATA_LEN (DATA_LEN)
    ) u_imm_gen (
        .inst (head_inst_q),
        .imm  (out_imm_o)
    );

    assign head_class    = classify(head_inst_q);
    assign out_inst_o    = head_inst_q;
    assign out_pc_o      = head_pc_q;
    assign out_class_o   = head_class;
    assign out_illegal_o = (head_class == ClsInvalid);

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl; accepted inputs queue expected outputs for the monitor.
module tb_decode_issue_ctrl;

    localparam logic [63:0] RstPc = 64'h0000_0000_dead_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [3:0]  cls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [3:0]  out_class;
    logic        out_illegal;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   cyc;
    logic mon_en = 1'b0;
    logic mon_rdy, mon_vld;
    exp_t mon_e;
    exp_t sb[$];
    logic [63:0] next_pc = 64'h8000_0000;

    logic [31:0] vi [16];
    logic [63:0] vm [16];
    logic [3:0]  vc [16];

    always #5 clk = ~clk;

    decode_issue_ctrl #(
        .DATA_LEN (64),
        .RESET_PC (RstPc)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_inst_i     (in_inst),
        .in_pc_i       (in_pc),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_inst_o    (out_inst),
        .out_pc_o      (out_pc),
        .out_imm_o     (out_imm),
        .out_class_o   (out_class),
        .out_illegal_o (out_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake expectations from the model occupancy, then pop on output transfers.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
`ifdef DECODE_SKID_EN
            mon_rdy = !flush && (sb.size() < 2);
`else
            mon_rdy = !flush && ((sb.size() == 0) || out_ready);
`endif
            mon_vld = !flush && (sb.size() != 0);
            check("in_ready", in_ready, mon_rdy);
            check("out_valid", out_valid, mon_vld);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got inst %h pc %h, expected none",
                             out_inst, out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    n_pop++;
                    check("out_inst", out_inst, mon_e.inst);
                    check("out_pc", out_pc, mon_e.pc);
                    check("out_imm", out_imm, mon_e.imm);
                    check("out_class", out_class, mon_e.cls);
                    check("out_illegal", out_illegal, mon_e.cls == 4'd15);
                end
            end
        end
    end

    // Presents vectors first..last in order; out_ready follows rdy_mask bit per cycle.
    task automatic run_stream(input int first, input int last, input logic [31:0] rdy_mask,
                              input int max_cyc, output int cycles);
        int  i;
        int  c;
        logic acc;
        i = first;
        c = 0;
        while (i <= last && c < max_cyc) begin
            in_valid  = 1'b1;
            in_inst   = vi[i];
            in_pc     = next_pc;
            out_ready = (c < 32) ? rdy_mask[c] : 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back('{inst: vi[i], pc: next_pc, imm: vm[i], cls: vc[i]});
                n_push++;
                next_pc += 64'd4;
                i++;
            end
            #1;
            c++;
        end
        in_valid = 1'b0;
        cycles = c;
        if (i <= last) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream_timeout: got %0d accepted, expected %0d", i - first,
                     last - first + 1);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_done", k < 20, 1'b1);
    endtask

    initial begin
        vi = '{32'hfff0a083, 32'h00000000, 32'h0080006f, 32'h00500093,
               32'h002081b3, 32'h0020a423, 32'hfe000ee3, 32'h123452b7,
               32'h80000317, 32'h00008067, 32'hfff3839b, 32'h003100bb,
               32'h00000073, 32'h0100b103, 32'h0ff0000f, 32'h00000001};
        vm = '{64'hffff_ffff_ffff_ffff, 64'h0, 64'h8, 64'h5,
               64'h0, 64'h8, 64'hffff_ffff_ffff_fffc, 64'h0000_0000_1234_5000,
               64'hffff_ffff_8000_0000, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h0,
               64'h0, 64'h10, 64'hff, 64'h0};
        vc = '{4'd2, 4'd15, 4'd5, 4'd1, 4'd0, 4'd3, 4'd4, 4'd7,
               4'd8, 4'd6, 4'd10, 4'd9, 4'd12, 4'd2, 4'd11, 4'd15};

        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, RstPc);
        check("rst_out_imm", out_imm, 64'h0);
        check("rst_out_class", out_class, 4'd15);
        check("rst_out_illegal", out_illegal, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Single instructions: visible the cycle after acceptance.
        run_stream(0, 0, 32'hffff_ffff, 5, cyc);
        check("lw_valid", out_valid, 1'b1);
        check("lw_class", out_class, 4'd2);
        check("lw_imm", out_imm, 64'hffff_ffff_ffff_ffff);
        check("lw_illegal", out_illegal, 1'b0);
        run_stream(1, 1, 32'hffff_ffff, 5, cyc);
        check("zero_valid", out_valid, 1'b1);
        check("zero_class", out_class, 4'd15);
        check("zero_illegal", out_illegal, 1'b1);
        run_stream(2, 2, 32'hffff_ffff, 5, cyc);
        check("jal_class", out_class, 4'd5);
        check("jal_imm", out_imm, 64'h8);

        run_stream(3, 10, 32'hffff_ffff, 20, cyc);
        check("throughput_cycles", cyc, 8);
        run_stream(11, 15, 32'hffff_fff8, 30, cyc);
        drain();

        // Flush with a new instruction offered in the same cycle.
        out_ready = 1'b0;
`ifdef DECODE_SKID_EN
        run_stream(3, 4, 32'h0, 5, cyc);
`else
        run_stream(3, 3, 32'h0, 5, cyc);
`endif
        in_valid  = 1'b1;
        in_inst   = vi[5];
        in_pc     = next_pc;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        @(posedge clk);
        sb.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_valid", out_valid, 1'b0);
        check("post_flush_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        run_stream(6, 6, 32'hffff_ffff, 5, cyc);
        drain();

        // Asynchronous reset while holding entries.
        out_ready = 1'b0;
`ifdef DECODE_SKID_EN
        run_stream(3, 4, 32'h0, 5, cyc);
`else
        run_stream(3, 3, 32'h0, 5, cyc);
`endif
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_inst", out_inst, 32'h0);
        check("mid_rst_pc", out_pc, RstPc);
        check("mid_rst_imm", out_imm, 64'h0);
        sb.delete();
        n_push = n_pop;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_pc", out_pc, RstPc);
        check("rel_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        run_stream(7, 7, 32'hffff_ffff, 5, cyc);
        drain();

        check("pop_count", n_pop, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
